// File: rtl/stack_ctrl.sv
// Push/pop controller for a single-port stack RAM clocked on the falling edge.
// Optional sticky overflow/underflow flags are built when STACK_CTRL_ERR_EN is defined.
module stack_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t      state, state_nxt;
    logic [AW:0] sp;
    logic        push_ok, pop_ok;

    assign level = sp;
    assign full  = (sp == DEPTH_L);
    assign empty = (sp == '0);
    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Push wins over a simultaneous pop; rejected requests keep the FSM in IDLE.
    always_comb begin
        state_nxt = state;
        push_ok   = 1'b0;
        pop_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (push) begin
                    if (!full) begin
                        push_ok   = 1'b1;
                        state_nxt = WR;
                    end
                end else if (pop && !empty) begin
                    pop_ok    = 1'b1;
                    state_nxt = RD;
                end
            end
            WR:      state_nxt = IDLE;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp         <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            ram_wren   <= push_ok;
            dout_valid <= 1'b0;
            if (push_ok) begin
                ram_data <= din;
                ram_addr <= AW'(sp);
            end
            if (pop_ok)
                ram_addr <= AW'(sp - ONE);
            if (state == WR)
                sp <= sp + ONE;
            // RAM registered the read address on the falling edge inside RD.
            if (state == CAP) begin
                dout       <= ram_q;
                dout_valid <= 1'b1;
                sp         <= sp - ONE;
            end
        end
    end

`ifdef STACK_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (state == IDLE) begin
            if (push && full)
                ovf <= 1'b1;
            if (!push && pop && empty)
                unf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: queue-based stack model, falling-edge RAM model,
// and a monitor that checks RAM writes and popped bytes as the DUT presents them.
module tb_stack_ctrl;

    localparam int DW = 8, AW = 5, DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n, push, pop;
    logic [DW-1:0] din, dout, ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic [AW:0]   level;
    logic          ready, dout_valid, full, empty, ovf, unf, ram_wren;

    int checks = 0, errors = 0;

    logic [DW-1:0]    stk[$];
    logic [DW-1:0]    exp_dout[$];
    logic [AW+DW-1:0] exp_wr[$];
    logic [DW-1:0]    last_dout = '0;
    logic             exp_ovf = 1'b0, exp_unf = 1'b0;
    logic [DW-1:0]    mem [DEPTH];

    stack_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .ready(ready), .dout(dout), .dout_valid(dout_valid), .level(level),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse and every popped byte must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ram_wren === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_data);
                end else begin
                    logic [AW+DW-1:0] w;
                    w = exp_wr.pop_front();
                    chk("write_addr_data", {ram_addr, ram_data}, w);
                end
            end
            if (dout_valid === 1'b1) begin
                if (exp_dout.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_dout_valid: dout %0h, none expected", dout);
                end else begin
                    logic [DW-1:0] v;
                    v = exp_dout.pop_front();
                    chk("pop_dout", dout, v);
                end
            end
        end
    end

    task automatic model_reset();
        stk.delete();
        last_dout = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic check_status(string tag);
        chk({tag, "_level"}, level, stk.size());
        chk({tag, "_full"},  full,  stk.size() == DEPTH);
        chk({tag, "_empty"}, empty, stk.size() == 0);
        chk({tag, "_dout"},  dout,  last_dout);
        chk({tag, "_ovf"},   ovf,   exp_ovf);
        chk({tag, "_unf"},   unf,   exp_unf);
    endtask

    // Issue one request at a falling edge with ready=1, then wait for ready to return.
    task automatic do_op(bit p, bit q, logic [DW-1:0] d);
        int lat, n;
        chk("ready_before_op", ready, 1);
        push = p; pop = q; din = d;
        lat = 1;
        if (p) begin
            if (stk.size() < DEPTH) begin
                exp_wr.push_back({AW'(stk.size()), d});
                stk.push_back(d);
                lat = 2;
            end else begin
`ifdef STACK_CTRL_ERR_EN
                exp_ovf = 1'b1;
`endif
            end
        end else if (q) begin
            if (stk.size() > 0) begin
                last_dout = stk.pop_back();
                exp_dout.push_back(last_dout);
                lat = 3;
            end else begin
`ifdef STACK_CTRL_ERR_EN
                exp_unf = 1'b1;
`endif
            end
        end
        @(posedge clk);
        #1 push = 1'b0; pop = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 8);
        chk("op_latency", n, lat);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] last32;
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        do_reset();
        chk("rst_ready", ready, 1);
        chk("rst_wren", ram_wren, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_dout_valid", dout_valid, 0);
        check_status("rst");

        do_op(1, 0, 8'h12);
        do_op(1, 0, 8'h77);
        do_op(1, 0, 8'h69);
        check_status("push3");
        do_op(0, 1, 8'h00);
        check_status("pop1");

        while (stk.size() < DEPTH) do_op(1, 0, 8'($urandom));
        last32 = stk[$];
        check_status("filled");
        do_op(1, 0, 8'hA5);
        check_status("overflow");
        do_op(0, 1, 8'h00);
        chk("pop_after_full", dout, last32);

        while (stk.size() > 0) do_op(0, 1, 8'h00);
        do_op(0, 1, 8'h00);
        check_status("underflow");

        do_op(1, 0, 8'h3C);
        do_op(1, 1, 8'h55);
        check_status("push_pop");
        do_op(0, 1, 8'h00);
        chk("push_pop_top", dout, 8'h55);

        // Reset while the pop is in RD: the aborted pop must never strobe dout_valid.
        push = 1'b0; pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        chk("abort_ready", ready, 1);
        check_status("abort");
        do_op(1, 0, 8'hC3);
        check_status("after_abort");

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)                        do_op(1, 1, 8'($urandom));
            else if ((i / 80) % 2 == 0)        do_op(r < 75, r >= 75, 8'($urandom));
            else                               do_op(r < 35, r >= 35, 8'($urandom));
            if (i % 25 == 0) check_status("random");
        end
        check_status("random_end");

        repeat (3) @(negedge clk);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_pops", exp_dout.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
